lut_arbiter: RTL and testbench
==============================

LUT_ARBITER -- requirements
Module: lut_arbiter

Interface
REQ-001 SHALL have parameter NUM_REQ, default 4: number of requesters sharing one single-port lookup RAM (2..8).
REQ-002 SHALL take RAM_WIDTH and RAM_ADDR_BITS from the shared `RAM_WIDTH / `RAM_ADDR_BITS defines; these are not local parameters.
REQ-003 SHALL have one clock and a synchronous, active-high reset: clk  in  1  rising-edge clock.
REQ-004 rst  in  1  synchronous active-high reset.
REQ-005 req_valid  in  NUM_REQ  per-requester request valid.
REQ-006 req_write  in  NUM_REQ  per-requester type: 1 = write, 0 = read.
REQ-007 req_addr  in  NUM_REQ*RAM_ADDR_BITS  packed addresses; requester i occupies slice i.
REQ-008 req_wdata  in  NUM_REQ*RAM_WIDTH  packed write data; requester i occupies slice i.
REQ-009 req_ready  out  NUM_REQ  one-hot grant; a transfer occurs when valid and ready are both high.
REQ-010 resp_valid  out  NUM_REQ  one-hot read-data-valid.
REQ-011 resp_data  out  RAM_WIDTH  read data, shared by all requesters.
REQ-012 clear_start  in  1  pulse that starts a zero-fill of the whole RAM.
REQ-013 busy  out  1  high while a clear is in progress.
REQ-014 ram_we  out  1  to the RAM write_enable.
REQ-015 ram_addr  out  RAM_ADDR_BITS  to the RAM address.
REQ-016 ram_wdata  out  RAM_WIDTH  to the RAM input_data.
REQ-017 ram_rdata  in  RAM_WIDTH  from the RAM output_data: registered, 1-cycle latency, read-before-write.

Function
REQ-018 SHALL have two states, ARB and CLEAR.
REQ-019 In ARB, clear_start=1 moves the FSM to CLEAR, and clear_start has priority over pending requests in that cycle.
REQ-020 CLEAR SHALL return to ARB after the cycle that issues address 2**RAM_ADDR_BITS-1.
REQ-021 In ARB, grant SHALL go to at most one requester per cycle, using round-robin starting from pointer rr_ptr.
REQ-022 After a grant to requester i, rr_ptr SHALL become (i+1) mod NUM_REQ; with no grant, rr_ptr holds.
REQ-023 req_ready SHALL be combinational from req_valid, rr_ptr and state; req_ready is all-zero in CLEAR.
REQ-024 A requester SHALL hold valid, addr and wdata stable until accepted; the arbiter never drops a pending request.
REQ-025 A transfer accepted at cycle N SHALL drive ram_we/ram_addr/ram_wdata from registers in cycle N+1.
REQ-026 An idle cycle SHALL drive ram_we=0, with ram_addr and ram_wdata holding their last values.
REQ-027 For a read accepted at N, resp_valid[i] SHALL be 1 in cycle N+2 only, with resp_data = ram_rdata passed through combinationally.
REQ-028 Writes SHALL produce no response.
REQ-029 Sustained throughput SHALL be one transfer per cycle, with back-to-back grants allowed.
REQ-030 Write then read to the same address in consecutive accepted cycles SHALL return the new data; no bypass logic is needed.
REQ-031 CLEAR SHALL issue ram_we=1, ram_wdata=0, ram_addr=0..2**RAM_ADDR_BITS-1, one address per cycle; busy=1 throughout.
REQ-032 Reads accepted before entering CLEAR SHALL still complete their responses normally.
REQ-033 clear_start while already in CLEAR SHALL be ignored; it does not restart the clear.
REQ-034 The address counter SHALL wrap only on exit from CLEAR; there is no overflow state.

Reset
REQ-035 On rst=1 at a rising edge: state=ARB, rr_ptr=0, clear counter=0, ram_we=0, ram_addr=0, ram_wdata=0, resp pipeline valids=0.
REQ-036 Output values under reset: req_ready=0 and busy=0 while rst=1; resp_valid=0 from the first cycle after reset.
REQ-037 Reset mid-CLEAR SHALL abandon the clear, leaving RAM contents partially zeroed; in-flight read responses are discarded.

Structure
REQ-038 RAM_WIDTH and RAM_ADDR_BITS stay in the shared matrix-vector parameter header; state encodings are localparams.
REQ-039 The round-robin grant logic SHALL be one sub-module, rr_arbiter, with ports req[NUM_REQ], ptr, grant[NUM_REQ].
REQ-040 The RAM is instantiated outside lut_arbiter.
REQ-041 Expected RTL size is 150-300 lines.

Verification (RAM_WIDTH=16, RAM_ADDR_BITS=4, NUM_REQ=4, real RAM model attached)
REQ-042 Directed test: req0 writes 0x00AB to addr 3; req1 then reads addr 3 in the next cycle -> resp_valid=4'b0010 two cycles after the read is accepted, resp_data=0x00AB.
REQ-043 Directed test: all four requesters hold reads from cycle 0 with rr_ptr=0 -> grants 0,1,2,3 in consecutive cycles; resp_valid 0001,0010,0100,1000 in cycles 2..5.
REQ-044 Directed test: req2 held valid continuously while req0 re-requests every cycle -> req2 is granted within NUM_REQ cycles, so there is no starvation.
REQ-045 Directed test: clear_start pulse while req1 is valid -> busy=1 for 16 cycles, ram_addr 0..15 with ram_we=1, req_ready=0 throughout; req1 is granted in the first cycle after busy falls, and a read of any address returns 0x0000.
REQ-046 Directed test: rst asserted at clear address 7 -> next cycle state=ARB, busy=0, ram_we=0; addresses 0..6 read 0, and addresses 8..15 keep their prior data.
REQ-047 Directed test: a read is accepted, then rst is asserted in the next cycle -> no resp_valid is ever seen for that read.

Source files
------------

// File: rtl/lut_arbiter_pkg.sv
// Shared types and constants for the lookup-RAM arbiter.
// RAM geometry comes from the matrix-vector header; these defaults apply only when it is absent.
`ifndef RAM_WIDTH
`define RAM_WIDTH 16
`endif
`ifndef RAM_ADDR_BITS
`define RAM_ADDR_BITS 4
`endif

package lut_arbiter_pkg;

    localparam int RAM_W  = `RAM_WIDTH;
    localparam int RAM_AW = `RAM_ADDR_BITS;

    localparam logic ST_ARB_ENC   = 1'b0;
    localparam logic ST_CLEAR_ENC = 1'b1;

    typedef enum logic {
        ST_ARB   = ST_ARB_ENC,
        ST_CLEAR = ST_CLEAR_ENC
    } state_t;

    function automatic int next_rr(input int idx, input int n);
        return (idx + 1 == n) ? 0 : idx + 1;
    endfunction

endpackage

// File: rtl/lut_arbiter_rr_arbiter.sv
// Round-robin one-hot grant: the first active request at or after ptr wins.
module rr_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int PTR_W   = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [PTR_W-1:0]   ptr,
    output logic [NUM_REQ-1:0] grant
);

    logic             found;
    logic [PTR_W-1:0] idx;

    always_comb begin
        grant = '0;
        found = 1'b0;
        idx   = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            idx = PTR_W'((int'(ptr) + k) % NUM_REQ);
            if (!found && req[idx]) begin
                grant[idx] = 1'b1;
                found      = 1'b1;
            end
        end
    end

endmodule

// File: rtl/lut_arbiter.sv
// Shares one registered single-port lookup RAM between NUM_REQ requesters and
// provides a full-RAM zero-fill sequence.
//
//   state    | meaning
//   ST_ARB   | round-robin arbitration, one transfer per cycle
//   ST_CLEAR | writing zero to every address, requests stalled
module lut_arbiter
    import lut_arbiter_pkg::*;
#(
    parameter int NUM_REQ = 4
) (
    input  logic                                clk,
    input  logic                                rst,
    input  logic [NUM_REQ-1:0]                  req_valid,
    input  logic [NUM_REQ-1:0]                  req_write,
    input  logic [NUM_REQ*`RAM_ADDR_BITS-1:0]   req_addr,
    input  logic [NUM_REQ*`RAM_WIDTH-1:0]       req_wdata,
    output logic [NUM_REQ-1:0]                  req_ready,
    output logic [NUM_REQ-1:0]                  resp_valid,
    output logic [`RAM_WIDTH-1:0]               resp_data,
    input  logic                                clear_start,
    output logic                                busy,
    output logic                                ram_we,
    output logic [`RAM_ADDR_BITS-1:0]           ram_addr,
    output logic [`RAM_WIDTH-1:0]               ram_wdata,
    input  logic [`RAM_WIDTH-1:0]               ram_rdata
);

    localparam int PW = $clog2(NUM_REQ);

    state_t              state;
    logic [PW-1:0]       rr_ptr;
    logic [RAM_AW-1:0]   clr_cnt;
    logic [NUM_REQ-1:0]  rd_pend;

    logic [NUM_REQ-1:0]  arb_req;
    logic [NUM_REQ-1:0]  grant;
    logic [PW-1:0]       gnt_idx;
    logic                any_gnt;
    logic [RAM_AW-1:0]   sel_addr;
    logic [RAM_W-1:0]    sel_wdata;
    logic                sel_write;
    logic [PW-1:0]       ptr_nxt;

    // clear_start wins over any pending request in the same cycle
    assign arb_req = (state == ST_ARB && !rst && !clear_start) ? req_valid : '0;

    rr_arbiter #(
        .NUM_REQ (NUM_REQ),
        .PTR_W   (PW)
    ) u_rr_arbiter (
        .req   (arb_req),
        .ptr   (rr_ptr),
        .grant (grant)
    );

    assign req_ready = grant;
    assign busy      = (state == ST_CLEAR) && !rst;
    assign resp_data = ram_rdata;

    always_comb begin
        gnt_idx = '0;
        any_gnt = 1'b0;
        for (int k = 0; k < NUM_REQ; k++) begin
            if (grant[k]) begin
                gnt_idx = PW'(k);
                any_gnt = 1'b1;
            end
        end
    end

    assign sel_addr  = req_addr[int'(gnt_idx)*RAM_AW +: RAM_AW];
    assign sel_wdata = req_wdata[int'(gnt_idx)*RAM_W +: RAM_W];
    assign sel_write = req_write[gnt_idx];
    assign ptr_nxt   = PW'(next_rr(int'(gnt_idx), NUM_REQ));

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= ST_ARB;
            rr_ptr     <= '0;
            clr_cnt    <= '0;
            ram_we     <= 1'b0;
            ram_addr   <= '0;
            ram_wdata  <= '0;
            rd_pend    <= '0;
            resp_valid <= '0;
        end else begin
            // read response pipeline: RAM address in N+1, data out in N+2
            rd_pend    <= grant & ~req_write;
            resp_valid <= rd_pend;

            case (state)
                ST_ARB: begin
                    if (clear_start) begin
                        state     <= ST_CLEAR;
                        clr_cnt   <= '0;
                        ram_we    <= 1'b1;
                        ram_addr  <= '0;
                        ram_wdata <= '0;
                    end else if (any_gnt) begin
                        ram_we    <= sel_write;
                        ram_addr  <= sel_addr;
                        ram_wdata <= sel_wdata;
                        rr_ptr    <= ptr_nxt;
                    end else begin
                        ram_we <= 1'b0;
                    end
                end
                ST_CLEAR: begin
                    ram_wdata <= '0;
                    if (&clr_cnt) begin
                        state   <= ST_ARB;
                        clr_cnt <= '0;
                        ram_we  <= 1'b0;
                    end else begin
                        clr_cnt  <= clr_cnt + 1'b1;
                        ram_addr <= clr_cnt + 1'b1;
                        ram_we   <= 1'b1;
                    end
                end
                default: state <= ST_ARB;
            endcase
        end
    end

endmodule

// File: tb/tb_lut_arbiter.sv
// Bench for lut_arbiter: directed scenarios plus random traffic against a
// transaction-level model (memory image, grant order, response schedule).
`ifndef RAM_WIDTH
`define RAM_WIDTH 16
`endif
`ifndef RAM_ADDR_BITS
`define RAM_ADDR_BITS 4
`endif

module tb_lut_arbiter;

    localparam int NR    = 4;
    localparam int AW    = `RAM_ADDR_BITS;
    localparam int RW    = `RAM_WIDTH;
    localparam int DEPTH = 1 << AW;

    logic             clk;
    logic             rst;
    logic [NR-1:0]    req_valid, req_write, req_ready, resp_valid;
    logic [NR*AW-1:0] req_addr;
    logic [NR*RW-1:0] req_wdata;
    logic [RW-1:0]    resp_data;
    logic             clear_start, busy, ram_we;
    logic [AW-1:0]    ram_addr;
    logic [RW-1:0]    ram_wdata, ram_rdata;
    logic [RW-1:0]    mem [DEPTH];

    lut_arbiter #(.NUM_REQ(NR)) dut (
        .clk         (clk),
        .rst         (rst),
        .req_valid   (req_valid),
        .req_write   (req_write),
        .req_addr    (req_addr),
        .req_wdata   (req_wdata),
        .req_ready   (req_ready),
        .resp_valid  (resp_valid),
        .resp_data   (resp_data),
        .clear_start (clear_start),
        .busy        (busy),
        .ram_we      (ram_we),
        .ram_addr    (ram_addr),
        .ram_wdata   (ram_wdata),
        .ram_rdata   (ram_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // registered-output, read-before-write RAM
    always @(posedge clk) begin
        ram_rdata <= mem[ram_addr];
        if (ram_we) mem[ram_addr] <= ram_wdata;
    end

    typedef struct {
        int          due;
        int          id;
        logic [RW-1:0] data;
    } rsp_t;

    logic [NR-1:0] v, wr;
    logic [AW-1:0] ad [NR];
    logic [RW-1:0] wd [NR];
    logic          rst_drv, clr;
    logic [NR-1:0] obs_rdy;

    int            ptr;
    bit            m_clear;
    int            m_cnt;
    logic [RW-1:0] shadow [DEPTH];
    logic          e_we;
    logic [AW-1:0] e_addr;
    logic [RW-1:0] e_wd;
    rsp_t          rq [$];
    int            cyc;
    int            n_assert, n_fail;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic set_req(input int id, input logic w, input int addr, input logic [RW-1:0] data);
        v[id]  = 1'b1;
        wr[id] = w;
        ad[id] = AW'(addr);
        wd[id] = data;
    endtask

    // One clock cycle: check registered outputs, drive inputs, check grant, advance the model.
    task automatic cycle();
        logic [NR-1:0] exp_rv, exp_g;
        logic [RW-1:0] exp_rd;
        int g, idx;
        exp_rv = '0;
        exp_rd = '0;
        if (rq.size() > 0 && rq[0].due == cyc) begin
            exp_rv = NR'(1) << rq[0].id;
            exp_rd = rq[0].data;
            void'(rq.pop_front());
        end
        chk("resp_valid", resp_valid, exp_rv);
        if (exp_rv != '0) chk("resp_data", resp_data, exp_rd);
        chk("ram_we", ram_we, e_we);
        chk("ram_addr", ram_addr, e_addr);
        chk("ram_wdata", ram_wdata, e_wd);

        rst         = rst_drv;
        clear_start = clr;
        req_valid   = v;
        req_write   = wr;
        for (int i = 0; i < NR; i++) begin
            req_addr[i*AW +: AW]  = ad[i];
            req_wdata[i*RW +: RW] = wd[i];
        end
        #1;
        obs_rdy = req_ready;
        chk("busy", busy, m_clear && !rst_drv);
        g = -1;
        exp_g = '0;
        if (!rst_drv && !m_clear && !clr) begin
            for (int k = 0; k < NR; k++) begin
                idx = (ptr + k) % NR;
                if (v[idx]) begin
                    g = idx;
                    break;
                end
            end
        end
        if (g >= 0) exp_g[g] = 1'b1;
        chk("req_ready", req_ready, exp_g);

        if (m_clear) shadow[m_cnt] = '0;
        if (rst_drv) begin
            ptr = 0; m_clear = 0; m_cnt = 0;
            e_we = 0; e_addr = '0; e_wd = '0;
            rq.delete();
        end else if (m_clear) begin
            if (m_cnt == DEPTH-1) begin
                m_clear = 0;
                e_we = 0;
            end else begin
                m_cnt++;
                e_we = 1; e_addr = AW'(m_cnt); e_wd = '0;
            end
        end else if (clr) begin
            m_clear = 1; m_cnt = 0;
            e_we = 1; e_addr = '0; e_wd = '0;
        end else if (g >= 0) begin
            e_we = wr[g]; e_addr = ad[g]; e_wd = wd[g];
            if (wr[g]) shadow[ad[g]] = wd[g];
            else rq.push_back('{due: cyc + 2, id: g, data: shadow[ad[g]]});
            ptr = (g + 1) % NR;
            v[g] = 1'b0;
        end else begin
            e_we = 0;
        end
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic drain();
        for (int k = 0; k < 16 && v != '0; k++) cycle();
        for (int k = 0; k < 3; k++) cycle();
    endtask

    task automatic read_one(input int id, input int addr, output logic [RW-1:0] d);
        set_req(id, 1'b0, addr, '0);
        cycle();
        cycle();
        d = resp_data;
    endtask

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1);
    end

    initial begin
        logic [RW-1:0] d;
        int nb, got, seen;
        n_assert = 0; n_fail = 0; cyc = 0;
        ptr = 0; m_clear = 0; m_cnt = 0;
        e_we = 0; e_addr = '0; e_wd = '0;
        for (int i = 0; i < DEPTH; i++) begin
            mem[i] = '0;
            shadow[i] = '0;
        end
        v = '0; wr = '0;
        for (int i = 0; i < NR; i++) begin
            ad[i] = '0;
            wd[i] = '0;
        end
        clr = 0; rst_drv = 1;
        rst = 1; clear_start = 0; req_valid = '0; req_write = '0;
        req_addr = '0; req_wdata = '0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        cycle();
        rst_drv = 0;

        // write 0x00AB to addr 3 by req0, then read it back by req1
        set_req(0, 1'b1, 3, 16'h00AB);
        cycle();
        chk("t042_grant_req0", obs_rdy, 4'b0001);
        set_req(1, 1'b0, 3, '0);
        cycle();
        chk("t042_grant_req1", obs_rdy, 4'b0010);
        cycle();
        chk("t042_resp_valid", resp_valid, 4'b0010);
        chk("t042_resp_data", resp_data, 16'h00AB);
        drain();

        // all four reading from pointer 0
        rst_drv = 1; cycle(); rst_drv = 0;
        for (int i = 0; i < NR; i++) set_req(i, 1'b0, i + 4, '0);
        for (int i = 0; i < 6; i++) begin
            if (i >= 2) chk($sformatf("t043_resp_valid_c%0d", i), resp_valid, NR'(1) << (i - 2));
            cycle();
            if (i < 4) chk($sformatf("t043_grant_c%0d", i), obs_rdy, NR'(1) << i);
        end
        drain();

        // req2 held while req0 re-requests every cycle
        set_req(2, 1'b0, 1, '0);
        got = 0;
        for (int i = 0; i < NR; i++) begin
            set_req(0, 1'b0, 2, '0);
            cycle();
            if (obs_rdy[2]) begin
                got = 1;
                break;
            end
        end
        chk("t044_req2_granted", got, 1);
        drain();

        // clear while req1 waits; a second clear_start mid-clear is ignored
        set_req(1, 1'b0, 9, '0);
        clr = 1;
        cycle();
        clr = 0;
        chk("t045_no_grant_on_clear", obs_rdy, 4'b0000);
        nb = 0;
        for (int i = 0; i <= DEPTH; i++) begin
            if (busy) nb++;
            if (i < DEPTH) begin
                chk($sformatf("t045_clr_addr%0d", i), ram_addr, i);
                chk($sformatf("t045_clr_we%0d", i), ram_we, 1);
            end
            clr = (i == 5);
            cycle();
            clr = 0;
        end
        chk("t045_busy_cycles", nb, DEPTH);
        chk("t045_grant_after_clear", obs_rdy, 4'b0010);
        cycle();
        chk("t045_resp_valid", resp_valid, 4'b0010);
        chk("t045_resp_zero", resp_data, 16'h0000);
        read_one(3, $urandom_range(0, DEPTH-1), d);
        chk("t045_rand_read_zero", d, 16'h0000);
        drain();

        // reset in the middle of a clear at address 7
        for (int a = 0; a < DEPTH; a++) begin
            set_req(0, 1'b1, a, RW'(16'h1000 + a));
            cycle();
        end
        clr = 1; cycle(); clr = 0;
        for (int i = 0; i < 7; i++) cycle();
        chk("t046_at_addr7", ram_addr, 7);
        rst_drv = 1; cycle(); rst_drv = 0;
        rst = 0; #1;
        chk("t046_busy_low", busy, 0);
        chk("t046_we_low", ram_we, 0);
        for (int a = 0; a < DEPTH; a++) begin
            if (a == 7) continue;
            read_one(3, a, d);
            chk($sformatf("t046_read_a%0d", a), d, (a < 7) ? 0 : 16'h1000 + a);
        end
        drain();

        // read accepted, then reset: response must never appear
        set_req(2, 1'b0, 5, '0);
        cycle();
        chk("t047_grant", obs_rdy, 4'b0100);
        rst_drv = 1; cycle(); rst_drv = 0;
        seen = 0;
        for (int i = 0; i < 4; i++) begin
            if (resp_valid != '0) seen = 1;
            cycle();
        end
        chk("t047_no_resp", seen, 0);

        // random traffic with occasional clears
        for (int n = 0; n < 400; n++) begin
            for (int i = 0; i < NR; i++) begin
                if (!v[i] && $urandom_range(0, 1) == 1)
                    set_req(i, 1'($urandom_range(0, 1)), $urandom_range(0, DEPTH-1), RW'($urandom));
            end
            clr = (!m_clear && $urandom_range(0, 59) == 0);
            cycle();
            clr = 0;
        end
        drain();

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
